// File: rtl/tree_walk_ctrl_pkg.sv
// tree_walk_pkg: node field layout, state codes and the fp64 ordering key shared by the tree walker
package tree_walk_pkg;
  localparam int TAG_LSB   = 0;
  localparam int TAG_MSB   = 3;
  localparam int RIGHT_LSB = 4;
  localparam int RIGHT_MSB = 15;
  localparam int LEFT_LSB  = 16;
  localparam int LEFT_MSB  = 27;
  localparam int THR_LSB   = 28;
  localparam int THR_MSB   = 91;
  localparam int FIDX_LSB  = 92;
  localparam int FIDX_MSB  = 95;
  localparam int ID_LSB    = 96;
  localparam int ID_MSB    = 107;
  localparam logic [3:0] TAG_INTERNAL = 4'h3;
  localparam int DEPTH_W = 6;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_EVAL = 2'd2, ST_DONE = 2'd3} state_e;
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] WAIT = ST_WAIT;
  localparam logic [1:0] EVAL = ST_EVAL;
  localparam logic [1:0] DONE = ST_DONE;
  // Maps an IEEE-754 double onto an unsigned key whose order matches numeric order (-0 below +0).
  function automatic logic [63:0] fp64_key(input logic [63:0] x);
    return x[63] ? ~x : x ^ {1'b1, 63'b0};
  endfunction
endpackage

// File: rtl/tree_walk_ctrl_if.sv
// tree_walk_ctrl_if: feature input, ROM port and result handshake of the tree walker
interface tree_walk_ctrl_if
  import tree_walk_pkg::*;
#(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_WIDTH   = 64
);
  logic                               in_valid;
  logic                               in_ready;
  logic [NUM_FEATURES*FEAT_WIDTH-1:0] features;
  logic [ADDR_WIDTH-1:0]              rom_addr;
  logic [NODE_WIDTH-1:0]              rom_data;
  logic                               out_valid;
  logic                               out_ready;
  logic                               out_class;
  logic                               out_error;
  logic [DEPTH_W-1:0]                 out_depth;
  modport slave (
    input  in_valid, features, rom_data, out_ready,
    output in_ready, rom_addr, out_valid, out_class, out_error, out_depth
  );
  modport master (
    output in_valid, features, rom_data, out_ready,
    input  in_ready, rom_addr, out_valid, out_class, out_error, out_depth
  );
endinterface

// File: rtl/tree_walk_ctrl_fp64_le_cmp.sv
// fp64_le_cmp: combinational a <= b on IEEE-754 doubles via order-preserving keys
module fp64_le_cmp
  import tree_walk_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        le
);
  assign le = fp64_key(a) <= fp64_key(b);
endmodule

// File: rtl/tree_walk_ctrl.sv
// tree_walk_ctrl: walks one decision-tree ROM from node 0 to a leaf; TREE_WALK_ID_CHECK_EN adds node_id checking
module tree_walk_ctrl
  import tree_walk_pkg::*;
#(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_WIDTH   = 64,
  parameter int MAX_DEPTH    = 32
) (
  input logic clk,
  input logic rst,
  tree_walk_ctrl_if.slave bus
);
  logic [1:0]                         state;
  logic [NUM_FEATURES*FEAT_WIDTH-1:0] feat_q;
  logic [DEPTH_W-1:0]                 depth;
  logic [FEAT_WIDTH-1:0]              feat_sel;
  logic [11:0]                        child;
  logic                               le;
  logic                               internal;
  logic                               id_bad;
  logic                               unused_bits;
  assign feat_sel = feat_q[int'(bus.rom_data[FIDX_MSB:FIDX_LSB])*FEAT_WIDTH +: FEAT_WIDTH];
  fp64_le_cmp u_cmp (
    .a (feat_sel),
    .b (bus.rom_data[THR_MSB:THR_LSB]),
    .le(le)
  );
  assign internal = bus.rom_data[TAG_MSB:TAG_LSB] == TAG_INTERNAL;
  assign child = le ? bus.rom_data[LEFT_MSB:LEFT_LSB] : bus.rom_data[RIGHT_MSB:RIGHT_LSB];
`ifdef TREE_WALK_ID_CHECK_EN
  assign id_bad = bus.rom_data[ID_LSB +: ADDR_WIDTH] != bus.rom_addr;
`else
  assign id_bad = 1'b0;
`endif
  assign unused_bits = ^{bus.rom_data[NODE_WIDTH-1:ID_LSB], child};
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.out_depth = depth;
  // Walk FSM: accept, issue address, evaluate the returned node, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      feat_q        <= '0;
      depth         <= '0;
      bus.rom_addr  <= '0;
      bus.out_class <= 1'b0;
      bus.out_error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          feat_q        <= bus.features;
          depth         <= '0;
          bus.rom_addr  <= '0;
          bus.out_class <= 1'b0;
          bus.out_error <= 1'b0;
          state         <= WAIT;
        end
        WAIT: state <= EVAL;
        EVAL: if (id_bad || (internal && depth == DEPTH_W'(MAX_DEPTH))) begin
          bus.out_error <= 1'b1;
          bus.out_class <= 1'b0;
          state         <= DONE;
        end else if (!internal) begin
          bus.out_class <= bus.rom_data[TAG_LSB];
          state         <= DONE;
        end else begin
          bus.rom_addr <= child[ADDR_WIDTH-1:0];
          depth        <= depth + 1'b1;
          state        <= WAIT;
        end
        default: if (bus.out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tree_walk_ctrl.sv
// tb_tree_walk_ctrl: scoreboard bench for tree_walk_ctrl with a ROM model and a real-valued reference walk
module tb_tree_walk_ctrl;
  import tree_walk_pkg::*;
  localparam logic [63:0] ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] HALF  = 64'h3FE0000000000000;
  localparam logic [63:0] TWO   = 64'h4000000000000000;
  localparam logic [63:0] NEG1  = 64'hBFF0000000000000;
  localparam logic [63:0] NEGH  = 64'hBFE0000000000000;
  localparam logic [63:0] NEGQ  = 64'hBFD0000000000000;
  localparam logic [63:0] PZERO = 64'h0000000000000000;
  localparam logic [63:0] NZERO = 64'h8000000000000000;

  typedef struct {
    bit cls;
    bit err;
    int depth;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tree_walk_ctrl_if #(.NODE_WIDTH(120), .ADDR_WIDTH(10), .NUM_FEATURES(16), .FEAT_WIDTH(64)) bus ();
  tree_walk_ctrl #(.NODE_WIDTH(120), .ADDR_WIDTH(10), .NUM_FEATURES(16), .FEAT_WIDTH(64), .MAX_DEPTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [119:0] rom [0:1023];
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int stray = 0;
  bit seen = 0;
  bit hs_prev = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.rom_data <= rom[bus.rom_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [119:0] mk(input int id, input int fi, input logic [63:0] thr,
                                      input int l, input int r, input logic [3:0] tag);
    logic [119:0] w;
    w = '0;
    w[107:96] = 12'(id);
    w[95:92]  = 4'(fi);
    w[91:28]  = thr;
    w[27:16]  = 12'(l);
    w[15:4]   = 12'(r);
    w[3:0]    = tag;
    return w;
  endfunction

  function automatic logic [1023:0] one_feat(input int idx, input logic [63:0] v);
    logic [1023:0] f;
    f = '0;
    f[idx*64 +: 64] = v;
    return f;
  endfunction

  // Reference walk: real-valued compares on the ROM contents, latency from node count.
  function automatic exp_t model(input logic [1023:0] fv);
    exp_t e;
    int a;
    int k;
    logic [119:0] w;
    e = '{cls: 1'b0, err: 1'b0, depth: 0, lat: 0};
    a = 0;
    k = 0;
    for (int s = 0; s < 100; s++) begin
      w = rom[a];
      k++;
`ifdef TREE_WALK_ID_CHECK_EN
      if (int'(w[105:96]) != a) begin
        e.err = 1'b1;
        break;
      end
`endif
      if (w[3:0] != 4'h3) begin
        e.cls = w[0];
        break;
      end
      if (e.depth == 32) begin
        e.err = 1'b1;
        break;
      end
      e.depth++;
      a = ($bitstoreal(fv[int'(w[95:92])*64 +: 64]) <= $bitstoreal(w[91:28])) ? int'(w[25:16]) : int'(w[13:4]);
    end
    e.lat = 2 * k + 1;
    return e;
  endfunction

  // Monitor: checks every cycle the result is presented and pops on handshake.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
      hs_prev = 1'b0;
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          stray++;
          chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          if (!seen) chk("latency", 64'(cyc - acc_cyc), 64'(q[0].lat));
          seen = 1'b1;
          chk("class", 64'(bus.out_class), 64'(q[0].cls));
          chk("error", 64'(bus.out_error), 64'(q[0].err));
          chk("depth", 64'(bus.out_depth), 64'(q[0].depth));
          chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
          if (bus.out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
            hs_prev = 1'b1;
            done_cnt++;
          end
        end
      end
    end
  end

  task automatic walk(input logic [1023:0] fv, input exp_t e, input int hold);
    int d0;
    int t;
    d0 = done_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.features = fv;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (hold > 0) begin
      t = 0;
      while (!bus.out_valid && t < 200) begin
        @(posedge clk);
        t++;
      end
      repeat (hold) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
    end
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      chk("walk_timeout", 64'(done_cnt), 64'(d0 + 1));
      q.delete();
    end
  endtask

  initial begin
    logic [1023:0] fv;
    int n;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.features = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
    chk("rst_results", {61'd0, bus.out_class, bus.out_error, bus.out_depth == 6'd0}, 64'd1);

    rom[0] = mk(0, 0, PZERO, 0, 0, 4'h1);
    walk('0, '{cls: 1'b1, err: 1'b0, depth: 0, lat: 3}, 0);

    rom[0] = mk(0, 2, ONE, 1, 2, 4'h3);
    rom[1] = mk(1, 0, PZERO, 0, 0, 4'h0);
    rom[2] = mk(2, 0, PZERO, 0, 0, 4'h1);
    walk(one_feat(2, HALF), '{cls: 1'b0, err: 1'b0, depth: 1, lat: 5}, 0);
    walk(one_feat(2, TWO),  '{cls: 1'b1, err: 1'b0, depth: 1, lat: 5}, 0);
    walk(one_feat(2, ONE),  '{cls: 1'b0, err: 1'b0, depth: 1, lat: 5}, 0);

    rom[0] = mk(0, 5, NEGH, 1, 2, 4'h3);
    walk(one_feat(5, NEG1), '{cls: 1'b0, err: 1'b0, depth: 1, lat: 5}, 0);
    walk(one_feat(5, NEGQ), '{cls: 1'b1, err: 1'b0, depth: 1, lat: 5}, 0);
    rom[0] = mk(0, 5, NZERO, 1, 2, 4'h3);
    walk(one_feat(5, PZERO), '{cls: 1'b1, err: 1'b0, depth: 1, lat: 5}, 0);
    rom[0] = mk(0, 5, PZERO, 1, 2, 4'h3);
    walk(one_feat(5, NZERO), '{cls: 1'b0, err: 1'b0, depth: 1, lat: 5}, 0);

    rom[0] = mk(0, 0, PZERO, 0, 0, 4'h3);
    walk('0, '{cls: 1'b0, err: 1'b1, depth: 32, lat: 67}, 0);

    rom[0] = mk(0, 0, PZERO, 0, 0, 4'h1);
    walk('0, '{cls: 1'b1, err: 1'b0, depth: 0, lat: 3}, 5);

`ifdef TREE_WALK_ID_CHECK_EN
    rom[0] = mk(0, 2, ONE, 1, 2, 4'h3);
    rom[1] = mk(2, 0, PZERO, 0, 0, 4'h1);
    walk(one_feat(2, HALF), '{cls: 1'b0, err: 1'b1, depth: 1, lat: 5}, 0);
    rom[1] = mk(1, 0, PZERO, 0, 0, 4'h0);
`endif

    rom[0] = mk(0, 0, PZERO, 0, 0, 4'h3);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (80) @(posedge clk);
    chk("abort_no_result", 64'(stray), 64'd0);

    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, 15);
      for (int a = 0; a < 16; a++) begin
        if (a < n - 1 && $urandom_range(0, 2) != 0)
          rom[a] = mk(a, $urandom_range(0, 15),
                      $realtobits((real'($urandom_range(0, 20)) - 10.0) * 0.5),
                      $urandom_range(a + 1, n - 1), $urandom_range(a + 1, n - 1), 4'h3);
        else
          rom[a] = mk(a, 0, PZERO, 0, 0, 4'($urandom_range(0, 1) ? $urandom_range(4, 15) : $urandom_range(0, 2)));
      end
      for (int f = 0; f < 16; f++)
        fv[f*64 +: 64] = $realtobits((real'($urandom_range(0, 20)) - 10.0) * 0.5);
      walk(fv, model(fv), $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tree_walk_ctrl.md
# tree_walk_ctrl

Sequencer for one decision-tree node ROM (120-bit nodes, 1-cycle synchronous read). It accepts a feature vector, walks the tree from node 0 by issuing ROM addresses and comparing the selected feature against each node threshold, and returns the leaf class. It sits between the feature front-end and a `tree_rom_*` instance; the ensemble voter consumes its result.

## Interface
- `NODE_WIDTH`, default 120: ROM word width.
- `ADDR_WIDTH`, default 10: ROM address width.
- `NUM_FEATURES`, default 16: features per vector; the 4-bit feature index selects one.
- `FEAT_WIDTH`, default 64: IEEE-754 double per feature.
- `MAX_DEPTH`, default 32: internal-node limit per walk.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: feature vector offered.
- `in_ready` out 1: controller idle and able to accept; `in_ready = (state==IDLE)`.
- `features` in NUM_FEATURES*FEAT_WIDTH: feature f at bits [f*64 +: 64].
- `rom_addr` out ADDR_WIDTH: registered address to the ROM.
- `rom_data` in NODE_WIDTH: ROM output, valid the cycle after the ROM samples `rom_addr`.
- `out_valid` out 1: result held until accepted.
- `out_ready` in 1: consumer accepts.
- `out_class` out 1: leaf class.
- `out_error` out 1: walk aborted.
- `out_depth` out 6: internal nodes traversed.

## Operation
- Node layout: [107:96] node_id, [95:92] feature_idx, [91:28] threshold, [27:16] left, [15:4] right, [3:0] tag. If tag == 4'h3 the node is internal; otherwise it is a leaf with class = tag[0]. An all-zero word is a leaf with class 0.
- Accept on `in_valid && in_ready`: latch `features`, set `rom_addr`=0 and depth=0, then go to WAIT.
- States:
  - IDLE: waits for accept, then WAIT.
  - WAIT: the ROM samples the address; go to EVAL.
  - EVAL: decode `rom_data`.
    - Leaf: latch class and go to DONE.
    - Internal with depth==MAX_DEPTH: set error, class 0, go to DONE.
    - Otherwise: `rom_addr` ← (feature ≤ threshold ? left : right)[ADDR_WIDTH-1:0], depth+1, back to WAIT.
  - DONE: `out_valid`=1. On `out_ready`, clear `out_valid` and go to IDLE.
- Compare: map each 64-bit value x to key = x[63] ? ~x : x ^ (1<<63), then compare keys unsigned. Equality goes left. NaN receives no special handling. -0 sorts below +0.
- `out_class`, `out_error` and `out_depth` are stable while `out_valid` is high.

## Timing
- Reset values: state IDLE, `rom_addr` 0, `out_valid` 0, `out_class` 0, `out_error` 0, `out_depth` 0, latched features 0. `in_ready` is 1 in the first cycle after reset is released.
- Accept in cycle 0. For a walk visiting k nodes (root to leaf inclusive), `out_valid` first rises in cycle 2k+1. Each node costs 2 cycles.
- `in_ready` goes low the cycle after accept. After the output handshake in cycle n, `in_ready` is 1 in cycle n+1; there is no overlap between walks.
- `rst` asserted in any state overrides all else. The walk is discarded and no result is emitted.

## Configuration
- `TREE_WALK_ID_CHECK_EN` defined: in EVAL, if node_id[ADDR_WIDTH-1:0] ≠ the issued `rom_addr`, set `out_error`=1 and class 0, and go to DONE.
- Macro absent: node_id is ignored and no comparator is built.

## Structure
- `tree_walk_pkg`:
  - field LSB/MSB constants for the node layout
  - `TAG_INTERNAL` = 4'h3
  - state enum
  - `DEPTH_W` = 6
- Sub-module `fp64_le_cmp`: combinational; inputs a, b (64 bits each); output `le` using the key mapping above.

## Test plan
- Root leaf: ROM[0] tag 4'h1 → `out_valid` in cycle 3, class 1, depth 0, error 0.
- Two-level tree:
  - Root: feature 2, threshold 0x3FF0000000000000 (1.0), left 1, right 2; ROM[1] tag 0, ROM[2] tag 1.
  - Feature 2 = 0x3FE0000000000000 (0.5) → class 0 in cycle 5, depth 1.
  - Feature 2 = 0x4000000000000000 (2.0) → class 1.
  - Feature 2 = 1.0 → class 0 (equality goes left).
- Negative compare: feature -1.0 (0xBFF0…0) against threshold -0.5 (0xBFE0…0) → left. Feature -0.25 (0xBFD0…0) → right.
- Loop: ROM[0] internal with both children 0, MAX_DEPTH=32 → `out_error`=1, depth 32, class 0, `out_valid` in cycle 67.
- Backpressure: hold `out_ready` low 5 cycles → `out_valid` and results stable, `in_ready` 0. On handshake, `in_ready` is 1 next cycle and a new vector is accepted.
- Reset at cycle 3 of a walk → IDLE next cycle with no `out_valid`. With `TREE_WALK_ID_CHECK_EN`, ROM[1].node_id=0x002 → `out_error`=1.
